instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/rv_pkg.sv | 35 +++
 rtl/instr_fetch_pc_gen.sv | 30 +++
 rtl/instr_fetch.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the fetch front end.
// Contents: XLEN, base opcode constants, fetch FSM state type,
//           next-PC select type and a word-alignment helper.
package rv_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_VALID  = 2'd2,
    S_SQUASH = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_t;

  // Clears the byte offset so fetches are always word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_gen.sv
// pc_gen: next fetch-PC selection and misaligned-target detection.
// Ports:
//   i_fetch_pc        current fetch address
//   i_sel             hold / +4 / redirect
//   i_redirect_target raw redirect target (may be misaligned)
//   o_next_pc_c       next fetch address (combinational)
//   o_misalign_c      redirect taken to a non-word-aligned target (combinational)
module pc_gen
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] i_fetch_pc,
  input  pc_sel_t         i_sel,
  input  logic [XLEN-1:0] i_redirect_target,
  output logic [XLEN-1:0] o_next_pc_c,
  output logic            o_misalign_c
);

  // Next-PC mux; +4 wraps naturally at 32 bits.
  always_comb begin
    o_next_pc_c = i_fetch_pc;
    unique case (i_sel)
      PC_INC:   o_next_pc_c = i_fetch_pc + XLEN'(4);
      PC_REDIR: o_next_pc_c = align_word(i_redirect_target);
      default:  o_next_pc_c = i_fetch_pc;
    endcase
  end

  assign o_misalign_c = (i_sel == PC_REDIR) && (i_redirect_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with redirect/squash.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/imem_addr            request to instruction memory (state-decoded)
//   imem_ack/imem_rdata           memory response
//   instr_valid/instr/opcode/pc   registered instruction to the decoder
//   instr_ready                   decoder accepts the instruction
//   redirect/redirect_target      jump / taken-branch redirect
//   misalign                      one-cycle pulse for a misaligned redirect target
//   fetch_count                   number of instructions accepted downstream
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_ack,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                instr_valid,
  output logic [XLEN-1:0]     instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [XLEN-1:0]     pc,
  input  logic                instr_ready,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_target,
  output logic                misalign,
  output logic [XLEN-1:0]     fetch_count
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_squash_addr;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;
  logic            r_instr_valid;
  logic            r_misalign;
  logic [XLEN-1:0] r_fetch_count;

  pc_sel_t         w_sel;
  logic            w_load_instr;
  logic            w_clear_instr;
  logic            w_accept;
  logic            w_save_squash;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misalign;

  pc_gen u_pc_gen (
    .i_fetch_pc        (r_fetch_pc),
    .i_sel             (w_sel),
    .i_redirect_target (redirect_target),
    .o_next_pc_c       (w_next_pc),
    .o_misalign_c      (w_misalign)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath control; redirect outranks ack and ready.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel         = PC_HOLD;
    w_load_instr  = 1'b0;
    w_clear_instr = 1'b0;
    w_accept      = 1'b0;
    w_save_squash = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect) begin
          w_sel = PC_REDIR;
          if (imem_ack) begin
            w_state_nxt = S_REQ;
          end else begin
            // Old request still in flight: remember its address until acked.
            w_state_nxt   = S_SQUASH;
            w_save_squash = 1'b1;
          end
        end else if (imem_ack) begin
          w_load_instr = 1'b1;
          w_state_nxt  = S_VALID;
        end
      end
      S_VALID: begin
        if (redirect) begin
          w_sel         = PC_REDIR;
          w_clear_instr = 1'b1;
          w_state_nxt   = S_REQ;
        end else if (instr_ready) begin
          w_sel         = PC_INC;
          w_clear_instr = 1'b1;
          w_accept      = 1'b1;
          w_state_nxt   = S_REQ;
        end
      end
      S_SQUASH: begin
        if (redirect) w_sel = PC_REDIR;
        if (imem_ack) w_state_nxt = S_REQ;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_squash_addr <= RESET_PC;
      r_instr       <= '0;
      r_pc          <= RESET_PC;
      r_instr_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_fetch_pc <= w_next_pc;
      r_misalign <= w_misalign;
      if (w_save_squash) r_squash_addr <= r_fetch_pc;
      if (w_load_instr) begin
        r_instr       <= imem_rdata;
        r_pc          <= r_fetch_pc;
        r_instr_valid <= 1'b1;
      end else if (w_clear_instr) begin
        // Zero instr while invalid so the decoder sees all-zero controls.
        r_instr       <= '0;
        r_instr_valid <= 1'b0;
      end
      if (w_accept) r_fetch_count <= r_fetch_count + XLEN'(1);
    end
  end

  // Request side decodes only from registered state; squash keeps the old address.
  assign imem_req    = (r_state == S_REQ) || (r_state == S_SQUASH);
  assign imem_addr   = (r_state == S_SQUASH) ? r_squash_addr : r_fetch_pc;

  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_W-1:0];
  assign pc          = r_pc;
  assign misalign    = r_misalign;
  assign fetch_count = r_fetch_count;

endmodule
